// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller. It drives one-cold columns, debounces the row
// press and release, and hands each accepted key to the consumer over valid/ready.
module keypad_scan_ctrl #(
  parameter int SCAN_TICKS = 49_999,
  parameter int DEB_CNT    = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] read,
  output logic [3:0] scan,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [1:0] o_state
);

  // state    | meaning
  // SCAN     | stepping columns, looking for a single-row press
  // DEBOUNCE | column held, counting matching dwell samples
  // HELD     | key emitted, column held until release is debounced
  typedef enum logic [1:0] {
    S_SCAN     = 2'b00,
    S_DEBOUNCE = 2'b01,
    S_HELD     = 2'b10
  } state_t;

  localparam int CW = (SCAN_TICKS > 0) ? $clog2(SCAN_TICKS + 1) : 1;
  localparam int DW = $clog2(DEB_CNT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_sample;
  logic [DW-1:0] r_deb;
  logic [3:0]    r_scan;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_overflow;

  logic          w_tick;
  logic          w_row_ok;
  logic [1:0]    w_row;
  logic [1:0]    w_col_next;
  logic          w_deb_done;
  logic          w_emit;
  logic [3:0]    w_emit_code;

  assign w_tick     = (r_cnt == CW'(SCAN_TICKS));
  assign w_col_next = r_col + 2'd1;
  assign w_deb_done = ((r_deb + DW'(1)) == DW'(DEB_CNT));

  // Multi-row patterns are ambiguous, so only exactly one low row counts.
  always_comb begin
    w_row_ok = 1'b1;
    w_row    = 2'd0;
    case (read)
      4'b0111: w_row = 2'd0;
      4'b1011: w_row = 2'd1;
      4'b1101: w_row = 2'd2;
      4'b1110: w_row = 2'd3;
      default: w_row_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_emit      = 1'b0;
    w_emit_code = {r_row, r_col};
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          w_emit      = (DEB_CNT == 1) && w_row_ok;
          w_emit_code = {w_row, r_col};
        end
        S_DEBOUNCE: w_emit = (read == r_sample) && w_deb_done;
        default:    w_emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= S_SCAN;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_sample    <= 4'hF;
      r_deb       <= '0;
      r_scan      <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);

      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_row_ok) begin
              r_row    <= w_row;
              r_sample <= read;
              if (DEB_CNT == 1) begin
                r_deb   <= '0;
                r_state <= S_HELD;
              end else begin
                r_deb   <= DW'(1);
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_col  <= w_col_next;
              r_scan <= ~(4'b0001 << w_col_next);
            end
          end
          S_DEBOUNCE: begin
            if (read == r_sample) begin
              if (w_deb_done) begin
                r_deb   <= '0;
                r_state <= S_HELD;
              end else begin
                r_deb <= r_deb + DW'(1);
              end
            end else begin
              r_deb   <= '0;
              r_col   <= w_col_next;
              r_scan  <= ~(4'b0001 << w_col_next);
              r_state <= S_SCAN;
            end
          end
          S_HELD: begin
            if (read == 4'hF) begin
              if (w_deb_done) begin
                r_deb   <= '0;
                r_col   <= w_col_next;
                r_scan  <= ~(4'b0001 << w_col_next);
                r_state <= S_SCAN;
              end else begin
                r_deb <= r_deb + DW'(1);
              end
            end else begin
              r_deb <= '0;
            end
          end
          default: begin
            r_deb   <= '0;
            r_state <= S_SCAN;
          end
        endcase
      end

      // Clear first so a same-cycle overflow set wins.
      if (ovf_clr) r_overflow <= 1'b0;

      if (w_emit) begin
        if (!r_key_valid || key_ready) begin
          r_key_code  <= w_emit_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign scan      = r_scan;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overflow  = r_overflow;
  assign o_state   = r_state;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with short dwells. Expected key
// codes are queued when a press is driven and checked when the consumer takes them.
module tb_keypad_scan_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] read;
  logic [3:0] scan;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       ovf_clr;
  logic [1:0] o_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_keys = 0;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(.SCAN_TICKS(3), .DEB_CNT(2)) dut (
    .Clk(Clk), .Rst(Rst), .read(read), .scan(scan), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .overflow(overflow),
    .ovf_clr(ovf_clr), .o_state(o_state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] col_drv(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Returns just after the edge that moves the scan onto column c (dwell start).
  task automatic wait_col(input int c);
    logic [3:0] prev;
    prev = scan;
    for (int i = 0; i < 100; i++) begin
      step();
      if (scan == col_drv(c) && scan != prev) return;
      prev = scan;
    end
    chk("wait_col", scan, col_drv(c));
  endtask

  always @(posedge Clk) begin
    if (Rst === 1'b1 && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_key", exp_q.size(), 1);
      end else begin
        chk("key_code", key_code, exp_q.pop_front());
        n_keys++;
      end
    end
  end

  initial begin
    Rst = 1'b0; read = 4'hF; key_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_scan", scan, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_state", o_state, 0);
    Rst = 1'b1;

    // Idle rotation: each column dwells 4 clocks.
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("idle_scan", scan, col_drv((k / 4) % 4));
    end
    chk("idle_valid", key_valid, 0);

    // Key 0x6: row1 at col2, accepted after two dwells.
    wait_col(2);
    read = 4'b1011;
    exp_q.push_back(4'h6);
    repeat (7) step();
    chk("k6_early", key_valid, 0);
    step();
    chk("k6_valid", key_valid, 1);
    chk("k6_code", key_code, 4'h6);
    chk("k6_state", o_state, 2);
    repeat (8) step();
    chk("k6_held_scan", scan, 4'b1011);
    chk("k6_held_state", o_state, 2);
    read = 4'hF;
    repeat (8) step();
    chk("k6_rel_state", o_state, 0);
    chk("k6_rel_scan", scan, col_drv(3));
    chk("k6_consumed", key_valid, 0);

    // One-dwell bounce at col3 must not produce a key.
    wait_col(3);
    read = 4'b0111;
    repeat (4) step();
    chk("bnc_state", o_state, 1);
    chk("bnc_scan", scan, col_drv(3));
    read = 4'hF;
    repeat (4) step();
    chk("bnc_resume_state", o_state, 0);
    chk("bnc_resume_scan", scan, 4'b1110);
    chk("bnc_keys", n_keys, 1);

    // Long hold of 0xF gives exactly one key.
    wait_col(3);
    read = 4'b1110;
    exp_q.push_back(4'hF);
    repeat (40) step();
    read = 4'hF;
    repeat (8) step();
    chk("hold_state", o_state, 0);
    chk("hold_scan", scan, 4'b1110);
    chk("hold_keys", n_keys, 2);

    // Unconsumed 0x0 followed by 0x5: 0x5 is dropped and overflow sets.
    key_ready = 1'b0;
    wait_col(0);
    read = 4'b0111;
    exp_q.push_back(4'h0);
    repeat (8) step();
    chk("ov_first_valid", key_valid, 1);
    chk("ov_first_code", key_code, 4'h0);
    read = 4'hF;
    repeat (8) step();
    wait_col(1);
    read = 4'b1011;
    repeat (8) step();
    chk("ov_code_kept", key_code, 4'h0);
    chk("ov_valid", key_valid, 1);
    chk("ov_set", overflow, 1);
    read = 4'hF;
    repeat (8) step();
    chk("ov_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ov_cleared", overflow, 0);
    key_ready = 1'b1;
    repeat (2) step();
    chk("ov_drained", key_valid, 0);
    chk("ov_keys", n_keys, 3);

    // Reset while HELD drops everything.
    key_ready = 1'b0;
    wait_col(0);
    read = 4'b1101;
    repeat (8) step();
    chk("rh_code", key_code, 4'h8);
    chk("rh_state", o_state, 2);
    Rst = 1'b0;
    step();
    chk("rh_scan", scan, 4'b1110);
    chk("rh_valid", key_valid, 0);
    chk("rh_ovf", overflow, 0);
    chk("rh_state0", o_state, 0);
    Rst = 1'b1;
    read = 4'hF;
    key_ready = 1'b1;
    repeat (4) step();
    chk("rh_after_valid", key_valid, 0);
    chk("queue_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
